// File: rtl/lcd_write_engine.sv
// HD44780-style 8-bit write engine: accepts one byte per valid/ready handshake and
// drives the setup / EN pulse / hold waveform, then waits out the controller execution time.
module lcd_write_engine #(
  parameter int T_PWRUP = 750000,
  parameter int T_SETUP = 2,
  parameter int T_EN    = 25,
  parameter int T_HOLD  = 2,
  parameter int T_SHORT = 2000,
  parameter int T_LONG  = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vld,
  input  logic        i_rs,
  input  logic [7:0]  i_data,
  output logic        o_rdy,
  output logic        o_done,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic [31:0] o_lcd_word
);

  localparam int M0    = (T_PWRUP > T_LONG)  ? T_PWRUP : T_LONG;
  localparam int M1    = (T_SHORT > T_EN)    ? T_SHORT : T_EN;
  localparam int M2    = (T_SETUP > T_HOLD)  ? T_SETUP : T_HOLD;
  localparam int M3    = (M0 > M1)           ? M0      : M1;
  localparam int T_MAX = (M3 > M2)           ? M3      : M2;
  localparam int CW    = $clog2(T_MAX) + 1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] LD_PWRUP = CW'(T_PWRUP);
  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP);
  localparam logic [CW-1:0] LD_EN    = CW'(T_EN);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD);
  localparam logic [CW-1:0] LD_SHORT = CW'(T_SHORT);
  localparam logic [CW-1:0] LD_LONG  = CW'(T_LONG);

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_IDLE  = 3'd1,
    S_SETUP = 3'd2,
    S_PULSE = 3'd3,
    S_HOLD  = 3'd4,
    S_WAIT  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          rdy_q, rdy_d;
  logic          done_q, done_d;
  logic          en_q, en_d;
  logic          on_q;
  logic          expired_s;
  logic          is_long_s;

  // Counter is loaded with the state's duration and the state ends when it reads one.
  assign expired_s = (cnt_q == CNT_ONE);
  // Clear-display (0x01) and return-home (0x02/0x03) need the long execution time.
  assign is_long_s = !rs_q && (data_q[7:2] == 6'b000000) && (data_q != 8'h00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CNT_ONE;
    rs_d    = rs_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      S_PWRUP: begin
        if (expired_s) state_d = S_IDLE;
      end
      S_IDLE: begin
        cnt_d = cnt_q;
        if (i_vld && rdy_q) begin
          state_d = S_SETUP;
          cnt_d   = LD_SETUP;
          rs_d    = i_rs;
          data_d  = i_data;
        end
      end
      S_SETUP: begin
        if (expired_s) begin
          state_d = S_PULSE;
          cnt_d   = LD_EN;
        end
      end
      S_PULSE: begin
        if (expired_s) begin
          state_d = S_HOLD;
          cnt_d   = LD_HOLD;
        end
      end
      S_HOLD: begin
        if (expired_s) begin
          state_d = S_WAIT;
          cnt_d   = is_long_s ? LD_LONG : LD_SHORT;
        end
      end
      S_WAIT: begin
        if (expired_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = LD_PWRUP;
      end
    endcase
    rdy_d = (state_d == S_IDLE);
    en_d  = (state_d == S_PULSE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_PWRUP;
      cnt_q   <= LD_PWRUP;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      en_q    <= en_d;
      on_q    <= 1'b1;
    end
  end

  assign o_rdy      = rdy_q;
  assign o_done     = done_q;
  assign o_lcd_on   = on_q;
  assign o_lcd_en   = en_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = data_q;
  assign o_lcd_word = {on_q, 20'h00000, en_q, rs_q, 1'b0, data_q};

endmodule

// File: tb/tb_lcd_write_engine.sv
// Self-checking bench for lcd_write_engine: expected pin values come from a timeline
// model built from the write-cycle durations, with randomized bytes.
module tb_lcd_write_engine;

  localparam int TP  = 10;
  localparam int TS  = 2;
  localparam int TE  = 3;
  localparam int TH  = 2;
  localparam int TSH = 5;
  localparam int TL  = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic        rs;
  logic [7:0]  data;
  logic        o_rdy, o_done, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
  logic [7:0]  o_lcd_data;
  logic [31:0] o_lcd_word;

  int nvec = 0;
  int nerr = 0;

  lcd_write_engine #(
    .T_PWRUP(TP), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_SHORT(TSH), .T_LONG(TL)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_vld(vld), .i_rs(rs), .i_data(data),
    .o_rdy(o_rdy), .o_done(o_done), .o_lcd_on(o_lcd_on), .o_lcd_en(o_lcd_en),
    .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw), .o_lcd_data(o_lcd_data),
    .o_lcd_word(o_lcd_word)
  );

  always #5 clk = ~clk;

  // Execution wait chosen from the byte: clear/home commands are slow.
  function automatic int wait_of(bit r, logic [7:0] d);
    return (!r && d >= 8'd1 && d <= 8'd3) ? TL : TSH;
  endfunction

  function automatic logic [31:0] word_of(bit on, bit en, bit r, logic [7:0] d);
    logic [31:0] w;
    w = 32'd0;
    if (on) w = w + 32'h8000_0000;
    if (en) w = w + 32'd1024;
    if (r)  w = w + 32'd512;
    return w + 32'(d);
  endfunction

  function automatic logic [45:0] pins();
    return {o_rdy, o_done, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_lcd_word};
  endfunction

  function automatic logic [45:0] exp_pins(bit rd, bit dn, bit on, bit en, bit r, logic [7:0] d);
    return {rd, dn, on, en, r, 1'b0, d, word_of(on, en, r, d)};
  endfunction

  task automatic wait_ready(string name);
    int g;
    g = 0;
    @(negedge clk);
    while (!o_rdy && g < 200) begin
      @(negedge clk);
      g++;
    end
    nvec++;
    if (o_rdy !== 1'b1) begin
      nerr++;
      $display("FAIL %s ready-timeout: rdy=%b required 1", name, o_rdy);
    end
  endtask

  task automatic test_reset();
    logic [45:0] e;
    rst = 1'b1; vld = 1'b0; rs = 1'b0; data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (pins() !== 46'd0) begin
      nerr++;
      $display("FAIL reset_pins: got %h required 0", pins());
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      e = exp_pins(k >= TP, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      nvec++;
      if (pins() !== e) begin
        nerr++;
        $display("FAIL pwrup_cycle%0d: got %h required %h", k, pins(), e);
      end
    end
  endtask

  task automatic run_xfer(string name, bit r, logic [7:0] d);
    int lat;
    logic [45:0] e;
    lat = TS + TE + TH + wait_of(r, d);
    wait_ready(name);
    vld = 1'b1; rs = r; data = d;
    @(posedge clk);
    #1;
    e = exp_pins(1'b0, 1'b0, 1'b1, 1'b0, r, d);
    nvec++;
    if (pins() !== e) begin
      nerr++;
      $display("FAIL %s accept: got %h required %h", name, pins(), e);
    end
    @(negedge clk);
    vld = 1'b0; rs = 1'($urandom); data = 8'($urandom);
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk);
      #1;
      e = exp_pins(k >= lat, k == lat, 1'b1, (k >= TS) && (k < TS + TE), r, d);
      nvec++;
      if (pins() !== e) begin
        nerr++;
        $display("FAIL %s cycle%0d: got %h required %h", name, k, pins(), e);
      end
    end
  endtask

  task automatic test_data_write();
    run_xfer("data41", 1'b1, 8'h41);
  endtask

  task automatic test_commands();
    logic [7:0] cmds [6];
    cmds = '{8'h01, 8'h02, 8'h38, 8'h00, 8'h03, 8'h04};
    foreach (cmds[i]) run_xfer($sformatf("cmd%02h", cmds[i]), 1'b0, cmds[i]);
  endtask

  task automatic test_random();
    bit r;
    logic [7:0] d;
    for (int i = 0; i < 10; i++) begin
      r = 1'($urandom);
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      run_xfer($sformatf("rand%0d", i), r, d);
    end
  endtask

  task automatic test_hold_busy();
    int rises;
    logic prev_en;
    rises = 0;
    prev_en = 1'b0;
    wait_ready("busy");
    vld = 1'b1; rs = 1'b0; data = 8'h10;
    @(posedge clk);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 2) data = 8'h20;
      if (k == 8) data = 8'h30;
      if (k == 14) vld = 1'b0;
      @(posedge clk);
      #1;
      if (o_lcd_en && !prev_en) rises++;
      prev_en = o_lcd_en;
      if (k == 12 || k == 6) begin
        nvec++;
        if (o_lcd_data !== 8'h10 || rises != 1) begin
          nerr++;
          $display("FAIL busy_first k=%0d: data=%h rises=%0d required 10/1", k, o_lcd_data, rises);
        end
      end
      if (k == 13) begin
        nvec++;
        if (o_lcd_data !== 8'h30 || o_rdy !== 1'b0) begin
          nerr++;
          $display("FAIL busy_second: data=%h rdy=%b required 30/0", o_lcd_data, o_rdy);
        end
      end
    end
    nvec++;
    if (rises != 2 || o_rdy !== 1'b1 || o_done !== 1'b1) begin
      nerr++;
      $display("FAIL busy_end: rises=%0d rdy=%b done=%b required 2/1/1", rises, o_rdy, o_done);
    end
  endtask

  task automatic test_back_to_back();
    int acc_t [$];
    int dones;
    int rw_bad;
    bit pre_rdy;
    bit acc;
    dones = 0;
    rw_bad = 0;
    wait_ready("b2b");
    vld = 1'b1; rs = 1'b1; data = 8'h30;
    for (int c = 0; c < 45; c++) begin
      pre_rdy = o_rdy;
      @(posedge clk);
      acc = pre_rdy && vld;
      if (acc) acc_t.push_back(c);
      #1;
      if (o_done) dones++;
      if (o_lcd_rw !== 1'b0 || o_lcd_word[8] !== 1'b0) rw_bad++;
      if (acc) begin
        nvec++;
        if (o_lcd_data !== 8'(8'h30 + acc_t.size() - 1)) begin
          nerr++;
          $display("FAIL b2b_latch%0d: got %h required %h", acc_t.size(), o_lcd_data,
                   8'(8'h30 + acc_t.size() - 1));
        end
      end
      @(negedge clk);
      if (acc) begin
        if (acc_t.size() < 3) data = 8'(8'h30 + acc_t.size());
        else vld = 1'b0;
      end
    end
    nvec++;
    if (acc_t.size() != 3 || dones != 3 || rw_bad != 0) begin
      nerr++;
      $display("FAIL b2b_counts: accepts=%0d dones=%0d rw_bad=%0d required 3/3/0",
               acc_t.size(), dones, rw_bad);
    end
    for (int i = 1; i < acc_t.size(); i++) begin
      nvec++;
      if (acc_t[i] - acc_t[i-1] != TS + TE + TH + TSH + 1) begin
        nerr++;
        $display("FAIL b2b_gap%0d: got %0d required %0d", i, acc_t[i] - acc_t[i-1],
                 TS + TE + TH + TSH + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    logic [45:0] e;
    dones = 0;
    wait_ready("midrst");
    vld = 1'b1; rs = 1'b1; data = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (o_lcd_en !== 1'b1) begin
      nerr++;
      $display("FAIL midrst_pulse: en=%b required 1", o_lcd_en);
    end
    #1 rst = 1'b1;
    #1;
    nvec++;
    if (pins() !== 46'd0) begin
      nerr++;
      $display("FAIL midrst_async: got %h required 0", pins());
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (o_done) dones++;
      if (k <= 11) begin
        e = exp_pins(k >= TP, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        nvec++;
        if (pins() !== e) begin
          nerr++;
          $display("FAIL midrst_pwrup%0d: got %h required %h", k, pins(), e);
        end
      end
    end
    nvec++;
    if (dones != 0) begin
      nerr++;
      $display("FAIL midrst_done: got %0d pulses required 0", dones);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_data_write();
    test_commands();
    test_random();
    test_hold_busy();
    test_back_to_back();
    test_reset_mid();
    run_xfer("post_rst", 1'b0, 8'h01);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
